// File: rtl/ifu_fetch.sv
// Single-outstanding instruction fetch unit: REQ -> RESP -> OUT, 3 cycles per instruction at best.
// Redirects while a read is in flight are deferred through flush_pending until the response drains.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [3:0]  ARID_VAL = 4'd0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        arvalid,
  input  logic        arready,
  output logic [31:0] araddr,
  output logic [3:0]  arid,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        rready,
  input  logic        rvalid,
  input  logic [1:0]  rresp,
  input  logic [31:0] rdata,
  input  logic        rlast,
  input  logic [3:0]  rid,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_err,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_RESP = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] target;
  logic        flush_pending;
  logic [31:0] redir_aligned;

  // Single-beat reads only, so the beat marker and ID carry no information.
  logic unused_inputs;
  assign unused_inputs = ^{rlast, rid, redirect_pc[1:0]};

  assign redir_aligned = {redirect_pc[31:2], 2'b00};

  assign araddr  = pc;
  assign arid    = ARID_VAL;
  assign arlen   = 8'd0;
  assign arsize  = 3'b010;
  assign arburst = 2'b01;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_REQ;
      pc            <= RESET_PC;
      target        <= RESET_PC;
      flush_pending <= 1'b0;
      arvalid       <= 1'b0;
      rready        <= 1'b0;
      inst_valid    <= 1'b0;
      inst          <= 32'd0;
      inst_pc       <= 32'd0;
      inst_err      <= 1'b0;
    end else begin
      case (state)
        S_REQ: begin
          // The address already presented is never retracted; a redirect only arms the flush.
          if (redirect_valid) begin
            flush_pending <= 1'b1;
            target        <= redir_aligned;
          end
          if (arvalid && arready) begin
            state   <= S_RESP;
            arvalid <= 1'b0;
            rready  <= 1'b1;
          end else begin
            arvalid <= 1'b1;
          end
        end

        S_RESP: begin
          if (rvalid && rready) begin
            rready        <= 1'b0;
            flush_pending <= 1'b0;
            if (redirect_valid) begin
              state   <= S_REQ;
              pc      <= redir_aligned;
              arvalid <= 1'b1;
            end else if (flush_pending) begin
              state   <= S_REQ;
              pc      <= target;
              arvalid <= 1'b1;
            end else begin
              state      <= S_OUT;
              inst_valid <= 1'b1;
              inst       <= rdata;
              inst_pc    <= pc;
              inst_err   <= (rresp != 2'b00);
            end
          end else if (redirect_valid) begin
            flush_pending <= 1'b1;
            target        <= redir_aligned;
          end
        end

        S_OUT: begin
          if (redirect_valid) begin
            state      <= S_REQ;
            pc         <= redir_aligned;
            inst_valid <= 1'b0;
            arvalid    <= 1'b1;
          end else if (inst_ready) begin
            state      <= S_REQ;
            pc         <= pc + 32'd4;
            inst_valid <= 1'b0;
            arvalid    <= 1'b1;
          end
        end

        default: begin
          state      <= S_REQ;
          arvalid    <= 1'b0;
          rready     <= 1'b0;
          inst_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: stimulus pushes expected AR addresses and instructions
// into queues; negedge monitor pops and compares on each handshake.
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        arvalid, arready = 1'b0;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rready, rvalid = 1'b0;
  logic [1:0]  rresp = 2'b00;
  logic [31:0] rdata = 32'd0;
  logic        rlast = 1'b1;
  logic [3:0]  rid = 4'd0;
  logic        inst_valid, inst_ready = 1'b0;
  logic [31:0] inst, inst_pc;
  logic        inst_err;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;

  ifu_fetch dut (
    .clk(clk), .rst(rst),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
    .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .rready(rready), .rvalid(rvalid), .rresp(rresp), .rdata(rdata),
    .rlast(rlast), .rid(rid),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .inst_pc(inst_pc), .inst_err(inst_err),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic [31:0] pc;
    logic        err;
  } exp_t;

  logic [31:0] exp_ar[$];
  exp_t        exp_inst[$];
  int          total = 0;
  int          passed = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          prev_acc_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: compares every handshake against the queues and checks hold rules.
  logic        ar_wait = 1'b0, out_wait = 1'b0;
  logic [31:0] ar_hold, hold_inst, hold_pc;
  logic        hold_err;

  always @(negedge clk) begin
    if (!rst) begin
      ar_wait  = 1'b0;
      out_wait = 1'b0;
    end else begin
      if (arvalid) begin
        if (ar_wait) chk("araddr_stable", araddr, ar_hold);
        if (arready) begin
          chk("ar_expected", 32'(exp_ar.size() != 0), 32'd1);
          if (exp_ar.size() != 0) chk("araddr", araddr, exp_ar.pop_front());
        end
        ar_wait = !arready;
        ar_hold = araddr;
      end else begin
        ar_wait = 1'b0;
      end

      if (inst_valid) begin
        chk("inst_expected", 32'(exp_inst.size() != 0), 32'd1);
        chk("no_ar_in_out", {30'd0, arvalid, rready}, 32'd0);
        if (out_wait) begin
          chk("inst_stable", inst, hold_inst);
          chk("inst_pc_stable", inst_pc, hold_pc);
          chk("inst_err_stable", 32'(inst_err), 32'(hold_err));
        end
        if (inst_ready && exp_inst.size() != 0) begin
          exp_t e;
          e = exp_inst.pop_front();
          chk("inst", inst, e.d);
          chk("inst_pc", inst_pc, e.pc);
          chk("inst_err", 32'(inst_err), 32'(e.err));
          prev_acc_cyc = acc_cyc;
          acc_cyc      = cyc;
        end
        out_wait  = !inst_ready;
        hold_inst = inst;
        hold_pc   = inst_pc;
        hold_err  = inst_err;
      end else begin
        out_wait = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_ar(input int dly);
    int n = 0;
    while (!arvalid && n < 20) begin
      step();
      n++;
    end
    chk("arvalid_timeout", 32'(arvalid), 32'd1);
    arready = 1'b0;
    repeat (dly) step();
    arready = 1'b1;
    step();
    arready = 1'b0;
  endtask

  task automatic do_r(input logic [31:0] d, input logic [1:0] resp);
    chk("rready_in_resp", 32'(rready), 32'd1);
    rvalid = 1'b1;
    rdata  = d;
    rresp  = resp;
    step();
    rvalid = 1'b0;
  endtask

  task automatic do_out(input int hold);
    chk("inst_valid_out", 32'(inst_valid), 32'd1);
    inst_ready = 1'b0;
    repeat (hold) step();
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] addr, input logic [31:0] d,
                       input logic [1:0] resp, input int hold);
    exp_t e;
    exp_ar.push_back(addr);
    do_ar(0);
    e.d = d; e.pc = addr; e.err = (resp != 2'b00);
    exp_inst.push_back(e);
    do_r(d, resp);
    do_out(hold);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_arvalid", 32'(arvalid), 32'd0);
    chk("rst_rready", 32'(rready), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_inst_err", 32'(inst_err), 32'd0);
    chk("ar_consts", {20'd0, arid, arlen}, 32'd0);
    chk("ar_size_burst", {27'd0, arsize, arburst}, {27'd0, 3'b010, 2'b01});
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arvalid_before_edge", 32'(arvalid), 32'd0);
    step();
    chk("arvalid_first_edge", 32'(arvalid), 32'd1);
    chk("araddr_first_edge", araddr, 32'h8000_0000);

    // Basic fetch, then a back-to-back one for throughput
    fetch(32'h8000_0000, 32'h0000_0013, 2'b00, 0);
    fetch(32'h8000_0004, 32'h0000_0113, 2'b00, 0);
    chk("throughput_cycles", 32'(acc_cyc - prev_acc_cyc), 32'd3);

    // Decode stalls 5 cycles
    fetch(32'h8000_0008, 32'h0010_0093, 2'b00, 5);

    // Redirect in RESP: response dropped
    exp_ar.push_back(32'h8000_000C);
    do_ar(0);
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
    step();
    redirect_valid = 1'b0;
    do_r(32'hDEAD_0001, 2'b00);
    chk("drop_resp_redirect", 32'(inst_valid), 32'd0);

    // arready low 4 cycles with redirects during the wait; last one wins
    exp_ar.push_back(32'h8000_0100);
    chk("arvalid_after_drop", 32'(arvalid), 32'd1);
    arready = 1'b0;
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0200;
    step();
    redirect_pc = 32'h8000_0300;
    step();
    redirect_valid = 1'b0;
    step();
    arready = 1'b1;
    step();
    arready = 1'b0;
    do_r(32'hDEAD_0002, 2'b00);
    chk("drop_resp_flush", 32'(inst_valid), 32'd0);

    // Error response still delivered, pc advances
    fetch(32'h8000_0300, 32'h1234_5678, 2'b10, 0);

    // Redirect in OUT with inst_ready: delivered, misaligned target masked
    exp_ar.push_back(32'h8000_0304);
    do_ar(0);
    e.d = 32'h0000_0073; e.pc = 32'h8000_0304; e.err = 1'b0;
    exp_inst.push_back(e);
    do_r(32'h0000_0073, 2'b00);
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF; inst_ready = 1'b1;
    step();
    redirect_valid = 1'b0; inst_ready = 1'b0;
    chk("inst_valid_drop_redirect", 32'(inst_valid), 32'd0);

    // PC wraps at top of address space
    fetch(32'hFFFF_FFFC, 32'h0000_0093, 2'b00, 0);

    // Redirect on the same cycle as R handshake
    exp_ar.push_back(32'h0000_0000);
    do_ar(0);
    rvalid = 1'b1; rdata = 32'hDEAD_0003; rresp = 2'b00;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0040;
    step();
    rvalid = 1'b0; redirect_valid = 1'b0;
    chk("drop_resp_same_cycle", 32'(inst_valid), 32'd0);

    // Reset in RESP, late rvalid ignored, fresh fetch at reset PC
    exp_ar.push_back(32'h0000_0040);
    do_ar(0);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_rready", 32'(rready), 32'd0);
    chk("async_rst_arvalid", 32'(arvalid), 32'd0);
    rvalid = 1'b1; rdata = 32'hDEAD_0004;
    step();
    step();
    #2;
    rst = 1'b1;
    step();
    chk("post_rst_arvalid", 32'(arvalid), 32'd1);
    chk("post_rst_araddr", araddr, 32'h8000_0000);
    chk("post_rst_rready", 32'(rready), 32'd0);
    rvalid = 1'b0;
    fetch(32'h8000_0000, 32'h0000_0013, 2'b00, 1);

    step();
    chk("ar_queue_empty", 32'(exp_ar.size()), 32'd0);
    chk("inst_queue_empty", 32'(exp_inst.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
